// File: rtl/pr_timer_pkg.sv
// pr_timer_pkg: register offsets, CTRL bit positions, mode codes and FSM states for pr_timer
package pr_timer_pkg;
   localparam logic [1:0] CTRL_OFF   = 2'b00;
   localparam logic [1:0] PRESET_OFF = 2'b01;
   localparam logic [1:0] COUNT_OFF  = 2'b10;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;
   localparam logic [1:0] MODE_RELOAD = 2'b01;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;
endpackage

// File: rtl/pr_timer.sv
// pr_timer: bus-mapped one-shot / auto-reload down-counter with maskable interrupt
module pr_timer
   import pr_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h00007F00,
   parameter int unsigned IRQ_MODE1_PULSE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);
   state_t state, state_nx;
   logic [3:0] ctrl;
   logic [31:0] preset, count, count_nx;
   logic irq_pend, pend_set, pend_clr, en_clr;
   logic [1:0] off;
   logic sel, ctrl_wr, preset_wr;
   logic unused_ok;
   assign unused_ok = ^{Addr[1:0], IRQ_MODE1_PULSE[0]};
   assign off = Addr[3:2];
   assign sel = (Addr[31:4] == BASE_ADDR[31:4]) && (off != 2'b11);
   assign ctrl_wr = WE && sel && off == CTRL_OFF;
   assign preset_wr = WE && sel && off == PRESET_OFF;
   assign Dout = !sel ? 32'd0 :
                 off == CTRL_OFF ? {28'd0, ctrl} :
                 off == PRESET_OFF ? preset :
                 off == COUNT_OFF ? count : 32'd0;
   assign IRQ = irq_pend & ctrl[CTRL_IM];
   always_comb begin
      state_nx = state;
      count_nx = count;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      en_clr = 1'b0;
      case (state)
         IDLE: state_nx = ctrl[CTRL_EN] ? LOAD : IDLE;
         LOAD: begin
            count_nx = preset;
            state_nx = CNT;
         end
         CNT: begin
            if (!ctrl[CTRL_EN]) state_nx = IDLE;
            else if (count == 32'd0) begin
               state_nx = INT;
               pend_set = 1'b1;
            end else count_nx = count - 32'd1;
         end
         default: begin
            if (ctrl[CTRL_MODE+:2] == MODE_RELOAD) begin
               state_nx = LOAD;
               pend_clr = 1'b1;
            end else begin
               state_nx = IDLE;
               en_clr = 1'b1;
            end
         end
      endcase
      // a bus write that disables the timer overrides whatever the FSM planned
      if (ctrl_wr && !Din[CTRL_EN]) begin
         state_nx = IDLE;
         count_nx = count;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ctrl <= 4'd0;
         preset <= 32'd0;
         count <= 32'd0;
         irq_pend <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         preset <= preset_wr ? Din : preset;
         ctrl <= ctrl_wr ? Din[3:0] : en_clr ? (ctrl & ~(4'd1 << CTRL_EN)) : ctrl;
         irq_pend <= ctrl_wr ? 1'b0 : pend_set | (irq_pend & ~pend_clr);
      end
   end
endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: directed and randomized checks of pr_timer against an arithmetic timing model
module tb_pr_timer;
   localparam logic [31:0] BASE = 32'h00007F00;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_PRE = BASE + 32'h4;
   localparam logic [31:0] A_CNT = BASE + 32'h8;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] Addr = 32'd0;
   logic WE = 1'b0;
   logic [31:0] Din = 32'd0;
   logic [31:0] Dout;
   logic IRQ;
   int n_chk = 0;
   int n_fail = 0;
   int unsigned c0 = 0;
   pr_timer #(.BASE_ADDR(BASE), .IRQ_MODE1_PULSE(1)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
   );
   always #5 clk = ~clk;
   // expected COUNT t edges after the enabling CTRL write, old = COUNT before the run
   function automatic int unsigned m_count(int n, bit reload, int t, int unsigned old);
      int u;
      if (t <= 1) return old;
      if (!reload) return (t - 2 >= n) ? 0 : n - (t - 2);
      u = (t - 1) % (n + 3);
      if (u == 0) return 0;
      return (u <= n + 1) ? n - (u - 1) : 0;
   endfunction
   function automatic bit m_pend(int n, bit reload, int t);
      if (t < n + 3) return 1'b0;
      if (!reload) return 1'b1;
      return ((t - 1) % (n + 3)) == n + 2;
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(logic [31:0] a, logic [31:0] d);
      Addr = a;
      Din = d;
      WE = 1'b1;
      tick();
      WE = 1'b0;
   endtask
   task automatic rd(string tag, logic [31:0] a, logic [31:0] exp);
      Addr = a;
      #1;
      chk(tag, Dout, exp);
   endtask
   task automatic run(int n, int mode, bit im, int len);
      bit reload;
      reload = (mode == 1);
      wr(A_PRE, n);
      wr(A_CTRL, {28'd0, im, mode[1:0], 1'b1});
      for (int t = 1; t <= len; t++) begin
         tick();
         rd("count", A_CNT, m_count(n, reload, t, c0));
         chk("irq", {31'd0, IRQ}, {31'd0, m_pend(n, reload, t) & im});
      end
      c0 = m_count(n, reload, len, c0);
   endtask
   task automatic stop();
      wr(A_CTRL, 32'd0);
      for (int i = 0; i < 5; i++) begin
         rd("frozen_count", A_CNT, c0);
         chk("stop_irq", {31'd0, IRQ}, 32'd0);
         tick();
      end
   endtask
   initial begin
      logic [31:0] exp_cnt [6];
      logic exp_irq [6];
      #2;
      rd("rst_ctrl", A_CTRL, 32'd0);
      rd("rst_pre", A_PRE, 32'd0);
      rd("rst_cnt", A_CNT, 32'd0);
      chk("rst_irq", {31'd0, IRQ}, 32'd0);
      #1 reset = 1'b1;
      tick();
      // one-shot, IRQ at edge 8 and held, Enable self-clears
      run(5, 0, 1'b1, 12);
      rd("oneshot_ctrl", A_CTRL, 32'h8);
      wr(A_CTRL, 32'h8);
      chk("oneshot_clear", {31'd0, IRQ}, 32'd0);
      // auto-reload, four-plus periods
      run(3, 1, 1'b1, 27);
      stop();
      // masked one-shot and ignored COUNT write
      run(2, 0, 1'b0, 8);
      wr(A_CNT, 32'hFFFF);
      rd("count_ro", A_CNT, 32'd0);
      chk("mask_irq", {31'd0, IRQ}, 32'd0);
      wr(A_CTRL, 32'h9);
      chk("im_set_irq", {31'd0, IRQ}, 32'd0);
      wr(A_CTRL, 32'h0);
      chk("im_stop_irq", {31'd0, IRQ}, 32'd0);
      rd("im_stop_cnt", A_CNT, 32'd0);
      // disable on the edge that would enter INT
      run(2, 0, 1'b1, 4);
      wr(A_CTRL, 32'h8);
      for (int i = 0; i < 4; i++) begin
         chk("coll_irq", {31'd0, IRQ}, 32'd0);
         rd("coll_cnt", A_CNT, 32'd0);
         tick();
      end
      rd("coll_ctrl", A_CTRL, 32'h8);
      // PRESET write during CNT applies only at the next reload
      run(3, 1, 1'b1, 3);
      exp_cnt = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd7, 32'd6};
      exp_irq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      wr(A_PRE, 32'd7);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         rd("pre_cnt", A_CNT, exp_cnt[i]);
         chk("pre_irq", {31'd0, IRQ}, {31'd0, exp_irq[i]});
      end
      c0 = 6;
      stop();
      // out-of-range addresses
      wr(BASE + 32'hC, 32'hFFFFFFFF);
      wr(BASE + 32'h10, 32'hFFFFFFFF);
      rd("dec_ctrl", A_CTRL, 32'd0);
      rd("dec_pre", A_PRE, 32'd7);
      rd("dec_cnt", A_CNT, 32'd6);
      rd("dec_dout_c", BASE + 32'hC, 32'd0);
      rd("dec_dout_10", BASE + 32'h10, 32'd0);
      // randomized runs
      for (int k = 0; k < 10; k++) begin
         int n;
         n = $urandom_range(0, 6);
         run(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 3 * (n + 3)));
         stop();
      end
      // asynchronous reset mid-count
      wr(A_PRE, 32'd20);
      wr(A_CTRL, 32'h9);
      for (int i = 0; i < 4; i++) tick();
      #2 reset = 1'b0;
      rd("mid_ctrl", A_CTRL, 32'd0);
      rd("mid_pre", A_PRE, 32'd0);
      rd("mid_cnt", A_CNT, 32'd0);
      chk("mid_irq", {31'd0, IRQ}, 32'd0);
      #1 reset = 1'b1;
      tick();
      wr(A_PRE, 32'd5);
      rd("post_rst_pre", A_PRE, 32'd5);
      rd("post_rst_cnt", A_CNT, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pr_timer.md
Name: pr_timer

Overview:
- Memory-mapped timer/counter that responds on the CPU's processor bus: address, write data, write enable and read data.
- Sits behind the system bridge and answers CPU loads and stores to its three registers.
- Raises a hardware interrupt line that the bridge routes into the CPU's HWInt[7:2] input.
- Two modes: one-shot, and auto-reload with a periodic IRQ pulse.

Parameters:
- BASE_ADDR, 32'h00007F00, byte address of register 0; the block decodes BASE_ADDR..BASE_ADDR+0xB.
- IRQ_MODE1_PULSE, 1, width in cycles of the mode-1 IRQ pulse (fixed at 1; the parameter only documents it).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Addr  in  32  processor-bus byte address (word-aligned)
- WE  in  1  bus write strobe, already qualified by the bridge (no pending exception)
- Din  in  32  bus write data
- Dout  out  32  read data (combinational)
- IRQ  out  1  interrupt request to the bridge/HWInt

Behaviour:
- Registers, at word offset from BASE_ADDR:
  - CTRL @0x0: bit0 Enable, bits[2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = allow). Bits 31:4 read 0.
  - PRESET @0x4: read/write.
  - COUNT @0x8: read-only; writes are ignored.
- Select: sel = (Addr[31:4] == BASE_ADDR[31:4]) && (Addr[3:2] != 2'b11).
  - A write takes effect at the clk edge when WE && sel.
  - Dout = selected register when sel, else 0.
- Reset values (reset low, async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, IRQ=0, Dout=0 (no select).
- FSM, evaluated per rising edge:
  - IDLE: if Enable -> LOAD; COUNT holds.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - if Enable==0 -> IDLE (COUNT freezes);
    - else if COUNT==0 -> INT and irq_pend <= 1;
    - else COUNT <= COUNT-1.
  - INT:
    - Mode one-shot: CTRL.Enable <= 0 -> IDLE; irq_pend stays 1.
    - Mode auto-reload: -> LOAD; irq_pend <= 0 (1-cycle pulse).
- IRQ = irq_pend & CTRL.IM, registered-state based (no Din combinational path).
- Timing with PRESET=N, measured from the edge that writes Enable=1:
  - IRQ rises after N+3 edges.
  - Auto-reload period is N+3 cycles.
- irq_pend clear: in one-shot mode, cleared by any CTRL write. An IM=0 write also hides IRQ.
- Simultaneous events:
  - A bus write to CTRL on the same edge as an FSM update of CTRL.Enable: the bus write wins.
  - The CTRL write also clears irq_pend.
  - A PRESET write during CNT does not alter COUNT; it is used at the next LOAD.
  - Writing Enable=0 in any state -> IDLE next edge; COUNT is retained.
- PRESET=0: LOAD -> CNT sees 0 -> INT. IRQ comes 3 edges after enable, with no wrap.
- COUNT never wraps below 0.
- Reset asserted mid-count aborts immediately to reset values.

Decomposition:
- Shared header/package holds:
  - register offsets (CTRL_OFF=2'b00, PRESET_OFF=2'b01, COUNT_OFF=2'b10);
  - CTRL bit positions;
  - mode codes;
  - FSM state encodings (IDLE, LOAD, CNT, INT as 2-bit).
- One module, no sub-module. Register file and FSM are small enough to stay flat.

Test Plan:
- Reset mid-count:
  - Stimulus: reset low at any time.
  - Required response: Dout of CTRL/PRESET/COUNT reads 0; IRQ=0; then write PRESET=5 and read back 5.
- One-shot, IRQ timing and clear:
  - Stimulus: PRESET=5, CTRL=0x9 (Enable, mode0, IM).
  - Required response: COUNT reads 5,4,3,2,1,0; IRQ rises exactly 8 edges after the CTRL write and stays high; CTRL.Enable reads 0.
  - Follow-up: write CTRL=0x8; IRQ falls next edge.
- Auto-reload periodicity:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required response: 1-cycle IRQ pulses every 6 cycles for at least 4 periods.
  - Follow-up: write CTRL=0x0; no further pulses and COUNT frozen.
- Masking and illegal writes:
  - Stimulus: CTRL=0x1 with PRESET=2; write COUNT=0xFFFF.
  - Required response: IRQ stays 0 throughout; the COUNT write is ignored.
  - Follow-up: set IM with CTRL=0x9 while irq_pend pending; since this is a CTRL write, pend clears and IRQ stays 0.
- Write/count collision:
  - Stimulus: write CTRL Enable=0 on the same edge the FSM would reach INT.
  - Required response: state IDLE, no IRQ.
  - Stimulus: write PRESET=7 during CNT.
  - Required response: the current countdown is unaffected; the next reload uses 7.
- Address decode:
  - Stimulus: WE to BASE_ADDR+0xC and to BASE_ADDR+0x10 with Din=0xFFFFFFFF.
  - Required response: all registers unchanged; Dout=0 for both addresses.
